// File: rtl/icache_pkg.sv
// Shared types and elaboration helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } cacheStateT;

  function automatic bit waysLegal(input int ways);
    return (ways == 1) || (ways == 2) || (ways == 4);
  endfunction

  // A one-way cache still gets a 1-bit pointer type so declarations stay legal.
  function automatic int ptrWidth(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int offWidth(input int blockWidth);
    return blockWidth - 2;
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and line-fill-side signals of the instruction cache.
interface icache_assoc_if #(
  parameter int BLOCK_WIDTH = 4
);
  logic                          fetchValid;
  logic [31:0]                   fetchAddr;
  logic                          fetchReady;
  logic                          instrOutValid;
  logic [31:0]                   instrOut;
  logic                          memReq;
  logic [31-BLOCK_WIDTH:0]       memReqAddr;
  logic                          memDataValid;
  logic [8*(2**BLOCK_WIDTH)-1:0] memDataIn;

  modport slave (
    input  fetchValid, fetchAddr, memDataValid, memDataIn,
    output fetchReady, instrOutValid, instrOut, memReq, memReqAddr
  );

  modport master (
    output fetchValid, fetchAddr, memDataValid, memDataIn,
    input  fetchReady, instrOutValid, instrOut, memReq, memReqAddr
  );
endinterface

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays with a combinational lookup port and one write port.
module icache_way #(
  parameter int SET_WIDTH = 6,
  parameter int TAG_WIDTH = 22,
  parameter int LINE_BITS = 128,
  parameter int OFF_W     = 2
) (
  input  logic                 clkIn,
  input  logic                 resetIn,
  input  logic                 clearIn,
  input  logic [SET_WIDTH-1:0] rdIndex,
  input  logic [TAG_WIDTH-1:0] rdTag,
  input  logic [OFF_W-1:0]     rdWord,
  output logic                 hitOut,
  output logic                 validOut,
  output logic [31:0]          wordOut,
  input  logic                 wrEn,
  input  logic [SET_WIDTH-1:0] wrIndex,
  input  logic [TAG_WIDTH-1:0] wrTag,
  input  logic [LINE_BITS-1:0] wrLine
);
  localparam int SETS = 1 << SET_WIDTH;

  logic [SETS-1:0]      validBits;
  logic [TAG_WIDTH-1:0] tagMem  [SETS];
  logic [LINE_BITS-1:0] dataMem [SETS];
  logic [LINE_BITS-1:0] rdLine;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clkIn) begin
    if (resetIn || clearIn) validBits <= '0;
    else if (wrEn)          validBits[wrIndex] <= 1'b1;
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents unobservable.
  always_ff @(posedge clkIn) begin
    if (wrEn) begin
      tagMem[wrIndex]  <= wrTag;
      dataMem[wrIndex] <= wrLine;
    end
  end

  assign rdLine   = dataMem[rdIndex];
  assign validOut = validBits[rdIndex];
  assign hitOut   = validOut && (tagMem[rdIndex] == rdTag);
  assign wordOut  = rdLine[{rdWord, 5'b0} +: 32];

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache: registered hit path, miss FSM, per-set round-robin refill.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int BLOCK_WIDTH = 4,
  parameter int SET_WIDTH   = 6,
  parameter int WAYS        = 2,
  parameter int TAG_WIDTH   = 32 - SET_WIDTH - BLOCK_WIDTH
) (
  input logic            clkIn,
  input logic            resetIn,
  input logic            flushIn,
  icache_assoc_if.slave  bus
);
  localparam int SETS        = 1 << SET_WIDTH;
  localparam int OFF_W       = offWidth(BLOCK_WIDTH);
  localparam int PTR_W       = ptrWidth(WAYS);
  localparam int LINE_BITS   = 8 << BLOCK_WIDTH;
  localparam int LINE_ADDR_W = 32 - BLOCK_WIDTH;

  if (!waysLegal(WAYS)) begin : gBadWays
    $error("icache_assoc: WAYS must be 1, 2 or 4");
  end

  cacheStateT             state, stateNext;
  logic [SET_WIDTH-1:0]   fetchSet, reqSet, rdIndex;
  logic [TAG_WIDTH-1:0]   fetchTag, reqTag;
  logic [OFF_W-1:0]       fetchOff, reqOff;
  logic [LINE_ADDR_W-1:0] reqLine;
  logic                   memReqQ, outValidQ;
  logic [31:0]            outWordQ;
  logic [WAYS-1:0]        wayHit, wayValid, wayWrEn;
  logic [31:0]            wayWord [WAYS];
  logic                   hitAny, victimInvalid;
  logic [31:0]            hitWord, fillWord, outWordNext;
  logic [PTR_W-1:0]       victim, rrCur;
  logic                   clearAll, install, loadReq, outValidNext;
  logic                   unusedAddrBits;

  assign fetchSet       = bus.fetchAddr[SET_WIDTH+BLOCK_WIDTH-1:BLOCK_WIDTH];
  assign fetchTag       = bus.fetchAddr[31:SET_WIDTH+BLOCK_WIDTH];
  assign fetchOff       = bus.fetchAddr[BLOCK_WIDTH-1:2];
  assign unusedAddrBits = ^bus.fetchAddr[1:0];
  assign reqSet         = reqLine[SET_WIDTH-1:0];
  assign reqTag         = reqLine[LINE_ADDR_W-1:SET_WIDTH];
  // While a fill is outstanding the arrays are looked up at the pending set for victim choice.
  assign rdIndex        = (state == IDLE) ? fetchSet : reqSet;
  assign fillWord       = bus.memDataIn[{reqOff, 5'b0} +: 32];

  for (genvar w = 0; w < WAYS; w++) begin : gWay
    icache_way #(
      .SET_WIDTH(SET_WIDTH), .TAG_WIDTH(TAG_WIDTH), .LINE_BITS(LINE_BITS), .OFF_W(OFF_W)
    ) uWay (
      .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearAll),
      .rdIndex(rdIndex), .rdTag(fetchTag), .rdWord(fetchOff),
      .hitOut(wayHit[w]), .validOut(wayValid[w]), .wordOut(wayWord[w]),
      .wrEn(wayWrEn[w]), .wrIndex(reqSet), .wrTag(reqTag), .wrLine(bus.memDataIn)
    );
    assign wayWrEn[w] = install && (victim == PTR_W'(w));
  end

  if (WAYS > 1) begin : gRr
    logic [SETS-1:0][PTR_W-1:0] rr;
    assign rrCur = rr[reqSet];
    // WAYS is a power of two, so the natural wrap of the pointer is the modulo.
    always_ff @(posedge clkIn) begin
      if (resetIn)                       rr <= '0;
      else if (install && !victimInvalid) rr[reqSet] <= rrCur + PTR_W'(1);
    end
  end else begin : gNoRr
    assign rrCur = '0;
  end

  // Iterating downwards lets the lowest matching way win.
  always_comb begin
    hitAny  = 1'b0;
    hitWord = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (wayHit[w]) begin
        hitAny  = 1'b1;
        hitWord = wayWord[w];
      end
    end
  end

  always_comb begin
    victim        = rrCur;
    victimInvalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!wayValid[w]) begin
        victim        = PTR_W'(w);
        victimInvalid = 1'b1;
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) state <= IDLE;
    else         state <= stateNext;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext    = state;
    clearAll     = 1'b0;
    install      = 1'b0;
    loadReq      = 1'b0;
    outValidNext = 1'b0;
    outWordNext  = hitWord;
    unique case (state)
      IDLE: begin
        if (flushIn) begin
          clearAll = 1'b1;
        end else if (bus.fetchValid) begin
          if (hitAny) begin
            outValidNext = 1'b1;
          end else begin
            loadReq   = 1'b1;
            stateNext = FILL;
          end
        end
      end
      FILL: begin
        if (flushIn) begin
          clearAll  = 1'b1;
          stateNext = bus.memDataValid ? IDLE : DRAIN;
        end else if (bus.memDataValid) begin
          install      = 1'b1;
          outValidNext = 1'b1;
          outWordNext  = fillWord;
          stateNext    = IDLE;
        end
      end
      DRAIN: begin
        clearAll = flushIn;
        if (bus.memDataValid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      memReqQ   <= 1'b0;
      reqLine   <= '0;
      reqOff    <= '0;
      outValidQ <= 1'b0;
      outWordQ  <= '0;
    end else begin
      memReqQ   <= (stateNext != IDLE);
      outValidQ <= outValidNext;
      if (outValidNext) outWordQ <= outWordNext;
      if (loadReq) begin
        reqLine <= bus.fetchAddr[31:BLOCK_WIDTH];
        reqOff  <= fetchOff;
      end
    end
  end

  assign bus.fetchReady    = (state == IDLE) && !flushIn;
  assign bus.instrOutValid = outValidQ;
  assign bus.instrOut      = outWordQ;
  assign bus.memReq        = memReqQ;
  assign bus.memReqAddr    = reqLine;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (WAYS=2, SET_WIDTH=6, BLOCK_WIDTH=4).
module tb_icache_assoc;

  logic clkIn = 1'b0;
  logic resetIn;
  logic flushIn;
  int   total = 0;
  int   bad   = 0;

  icache_assoc_if #(.BLOCK_WIDTH(4)) bus ();

  icache_assoc #(.BLOCK_WIDTH(4), .SET_WIDTH(6), .WAYS(2)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .flushIn(flushIn), .bus(bus)
  );

  always #5 clkIn = ~clkIn;

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word k of line L is {L[23:0], 4'hA, k}, so every word used is distinct.
  function automatic logic [127:0] lineData(input logic [27:0] line);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {line[23:0], 4'hA, 4'(k)};
    return d;
  endfunction

  function automatic logic [31:0] wordAt(input logic [31:0] addr);
    logic [127:0] d;
    d = lineData(addr[31:4]);
    return d[{addr[3:2], 5'b0} +: 32];
  endfunction

  task automatic fetch(input logic [31:0] addr);
    bus.fetchValid = 1'b1;
    bus.fetchAddr  = addr;
    tick();
    bus.fetchValid = 1'b0;
  endtask

  task automatic respond(input string tag, input logic [27:0] line, input int lat);
    check({tag, " memReq"}, 64'(bus.memReq), 64'd1);
    check({tag, " memReqAddr"}, 64'(bus.memReqAddr), 64'(line));
    check({tag, " fetchReady"}, 64'(bus.fetchReady), 64'd0);
    repeat (lat) tick();
    check({tag, " memReq held"}, 64'(bus.memReq), 64'd1);
    bus.memDataValid = 1'b1;
    bus.memDataIn    = lineData(line);
    tick();
    bus.memDataValid = 1'b0;
    bus.memDataIn    = '0;
  endtask

  task automatic missFetch(input string tag, input logic [31:0] addr, input int lat);
    fetch(addr);
    check({tag, " no early out"}, 64'(bus.instrOutValid), 64'd0);
    respond(tag, addr[31:4], lat);
    check({tag, " outValid"}, 64'(bus.instrOutValid), 64'd1);
    check({tag, " instrOut"}, 64'(bus.instrOut), 64'(wordAt(addr)));
    check({tag, " memReq drop"}, 64'(bus.memReq), 64'd0);
  endtask

  task automatic hitFetch(input string tag, input logic [31:0] addr);
    fetch(addr);
    check({tag, " outValid"}, 64'(bus.instrOutValid), 64'd1);
    check({tag, " instrOut"}, 64'(bus.instrOut), 64'(wordAt(addr)));
    check({tag, " no memReq"}, 64'(bus.memReq), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetIn          = 1'b1;
    flushIn          = 1'b0;
    bus.fetchValid   = 1'b0;
    bus.fetchAddr    = '0;
    bus.memDataValid = 1'b0;
    bus.memDataIn    = '0;
    tick();
    tick();
    check("reset outValid", 64'(bus.instrOutValid), 64'd0);
    check("reset instrOut", 64'(bus.instrOut), 64'd0);
    check("reset memReq", 64'(bus.memReq), 64'd0);
    check("reset memReqAddr", 64'(bus.memReqAddr), 64'd0);
    resetIn = 1'b0;
    #1;
    check("reset fetchReady", 64'(bus.fetchReady), 64'd1);

    // Cold miss with a 7-cycle memory, then the response is a single pulse.
    missFetch("t1 miss 100", 32'h0000_0100, 7);
    tick();
    check("t1 pulse end", 64'(bus.instrOutValid), 64'd0);

    // Back-to-back hits on the freshly filled line.
    bus.fetchValid = 1'b1;
    for (int k = 1; k < 4; k++) begin
      bus.fetchAddr = 32'h0000_0100 + 32'(4 * k);
      tick();
      check("t2 b2b outValid", 64'(bus.instrOutValid), 64'd1);
      check("t2 b2b instrOut", 64'(bus.instrOut), 64'(wordAt(32'h0000_0100 + 32'(4 * k))));
      check("t2 b2b no memReq", 64'(bus.memReq), 64'd0);
    end
    bus.fetchValid = 1'b0;

    // Three lines in set 0: third fill evicts line 0x000 (rr=0), then rr points at way 1.
    missFetch("t3 fill 000", 32'h0000_0000, 3);
    missFetch("t3 fill 400", 32'h0000_0400, 2);
    missFetch("t3 fill 800", 32'h0000_0800, 1);
    hitFetch("t3 hit 404", 32'h0000_0404);
    missFetch("t3 evicted 00c", 32'h0000_000C, 2);
    hitFetch("t3 hit 808", 32'h0000_0808);

    // Flush two cycles into a fill: request held, data discarded, all lines invalid.
    fetch(32'h0000_0200);
    check("t4 memReq", 64'(bus.memReq), 64'd1);
    tick();
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    check("t4 drain memReq", 64'(bus.memReq), 64'd1);
    check("t4 drain fetchReady", 64'(bus.fetchReady), 64'd0);
    tick();
    tick();
    check("t4 drain memReq held", 64'(bus.memReq), 64'd1);
    bus.memDataValid = 1'b1;
    bus.memDataIn    = lineData(28'h000_0020);
    tick();
    bus.memDataValid = 1'b0;
    bus.memDataIn    = '0;
    check("t4 drain no out", 64'(bus.instrOutValid), 64'd0);
    check("t4 drain memReq drop", 64'(bus.memReq), 64'd0);
    check("t4 idle fetchReady", 64'(bus.fetchReady), 64'd1);
    missFetch("t4 refetch 200", 32'h0000_0200, 2);
    missFetch("t4 flushed 808", 32'h0000_0808, 1);

    // Flush in IDLE blocks a request to a cached line and invalidates it.
    bus.fetchValid = 1'b1;
    bus.fetchAddr  = 32'h0000_0204;
    flushIn        = 1'b1;
    #1;
    check("t4 flush fetchReady", 64'(bus.fetchReady), 64'd0);
    tick();
    flushIn        = 1'b0;
    bus.fetchValid = 1'b0;
    check("t4 flush no out", 64'(bus.instrOutValid), 64'd0);
    check("t4 flush no memReq", 64'(bus.memReq), 64'd0);
    missFetch("t4 after flush 204", 32'h0000_0204, 1);

    // Stray fill data while IDLE changes nothing.
    bus.memDataValid = 1'b1;
    bus.memDataIn    = {$urandom, $urandom, $urandom, $urandom};
    tick();
    bus.memDataValid = 1'b0;
    bus.memDataIn    = '0;
    check("t5 stray no out", 64'(bus.instrOutValid), 64'd0);
    check("t5 stray no memReq", 64'(bus.memReq), 64'd0);
    check("t5 stray instrOut held", 64'(bus.instrOut), 64'(wordAt(32'h0000_0204)));
    check("t5 stray fetchReady", 64'(bus.fetchReady), 64'd1);
    hitFetch("t5 hit 208", 32'h0000_0208);

    // Reset in the middle of a fill.
    fetch(32'h0000_0300);
    check("t6 memReq", 64'(bus.memReq), 64'd1);
    tick();
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    check("t6 memReq", 64'(bus.memReq), 64'd0);
    check("t6 outValid", 64'(bus.instrOutValid), 64'd0);
    check("t6 instrOut", 64'(bus.instrOut), 64'd0);
    check("t6 memReqAddr", 64'(bus.memReqAddr), 64'd0);
    check("t6 fetchReady", 64'(bus.fetchReady), 64'd1);
    missFetch("t6 after reset 208", 32'h0000_0208, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
